// File: rtl/axis_pkt_arb_pkg.sv
// -----------------------------------------------------------------------------
// axis_pkt_arb_pkg
// Shared definitions for the AXI-Stream packet arbiter: FSM state encoding,
// the location of the src_port field inside tuser, and the counter width.
// -----------------------------------------------------------------------------
package axis_pkt_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int TUSER_W      = 128;
    localparam int GRANT_W      = 3;
    localparam int SRC_PORT_LSB = 16;
    localparam int SRC_PORT_MSB = 23;
    localparam int SRC_PORT_W   = SRC_PORT_MSB - SRC_PORT_LSB + 1;
    localparam int CNT_W        = 32;

    // One-hot-ish source tag: bit 2*grant set, anything past bit 7 falls off.
    function automatic logic [SRC_PORT_W-1:0] src_port_code(input logic [GRANT_W-1:0] grant);
        return 8'h01 << (32'(grant) * 2);
    endfunction

endpackage

// File: rtl/axis_pkt_arb_if.sv
// -----------------------------------------------------------------------------
// axis_pkt_arb_if
// AXI-Stream bundle of NP lanes packed side by side (lane i at [i*W +: W]).
// NP=N for the arbiter's slave side, NP=1 for its master side.
//   tdata  NP*DW     tstrb  NP*DW/8   tuser  NP*128
//   tvalid NP        tlast  NP        tready NP
// Modports: master drives payload/valid/last and samples ready; slave is the
// mirror image.
// -----------------------------------------------------------------------------
interface axis_pkt_arb_if #(
    parameter int NP = 1,
    parameter int DW = 64
);
    import axis_pkt_arb_pkg::*;

    logic [NP*DW-1:0]      tdata;
    logic [NP*DW/8-1:0]    tstrb;
    logic [NP*TUSER_W-1:0] tuser;
    logic [NP-1:0]         tvalid;
    logic [NP-1:0]         tlast;
    logic [NP-1:0]         tready;

    modport master (output tdata, output tstrb, output tuser,
                    output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tstrb, input tuser,
                    input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_pkt_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector: finds the first set bit of req scanning
// from last_grant+1 upward, wrapping mod N.
//   req        in  N  request vector
//   last_grant in  3  most recently served port
//   hit        out 1  at least one request present
//   idx        out 3  selected port (0 when hit=0)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   last_grant,
    output logic         hit,
    output logic [2:0]   idx
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] cand;

    // Scan furthest-first so the nearest requester after last_grant is the
    // one left standing, which avoids an early loop exit.
    always_comb begin
        // NOTE: every output gets a default before the loop; otherwise a path
        // with no request would leave them unassigned and infer a latch.
        hit  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(last_grant) + k) % N);
            if (req[cand]) begin
                hit = 1'b1;
                idx = 3'(cand);
            end
        end
    end
endmodule

// File: rtl/axis_pkt_arb.sv
// -----------------------------------------------------------------------------
// axis_pkt_arb
// Packet-granular round-robin arbiter merging N AXI-Stream slaves onto one
// master. A granted port holds the bus until its tlast beat is accepted; one
// idle cycle separates consecutive packets. tuser[23:16] of the merged stream
// carries a source tag derived from the granted port.
//   m_axis_aclk     in   clock
//   m_axis_aresetp  in   asynchronous active-high reset
//   s_axis          slave  N-lane input bundle
//   m_axis          master merged output bundle
//   grant_port      out  3     granted port, meaningful while busy=1
//   busy            out  1     packet in progress
//   pkt_cnt         out  N*32  per-port forwarded packet counters
// Build option: define AXIS_PKT_ARB_CNT_EN to implement the packet counters;
// otherwise pkt_cnt is tied to zero.
// -----------------------------------------------------------------------------
module axis_pkt_arb
    import axis_pkt_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 64
) (
    input  logic                 m_axis_aclk,
    input  logic                 m_axis_aresetp,
    axis_pkt_arb_if.slave        s_axis,
    axis_pkt_arb_if.master       m_axis,
    output logic [GRANT_W-1:0]   grant_port,
    output logic                 busy,
    output logic [N*CNT_W-1:0]   pkt_cnt
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = DW / 8;

    state_t             state;
    state_t             state_nxt;
    logic [GRANT_W-1:0] last_grant;
    logic [IW-1:0]      gsel;
    logic               pick_hit;
    logic [GRANT_W-1:0] pick_idx;
    logic               last_acc;

    assign gsel     = grant_port[IW-1:0];
    assign last_acc = (state == BUSY) & s_axis.tvalid[gsel] & m_axis.tready[0]
                      & s_axis.tlast[gsel];

    rr_pick #(.N(N)) u_rr_pick (
        .req        (s_axis.tvalid),
        .last_grant (last_grant),
        .hit        (pick_hit),
        .idx        (pick_idx)
    );

    // State register. last_grant resets to N-1 so port 0 wins first.
    always_ff @(posedge m_axis_aclk or posedge m_axis_aresetp) begin
        if (m_axis_aresetp) begin
            state      <= IDLE;
            grant_port <= '0;
            last_grant <= GRANT_W'(N - 1);
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state <= state_nxt;
            if (state == IDLE && pick_hit) grant_port <= pick_idx;
            if (last_acc)                  last_grant <= grant_port;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_hit) state_nxt = BUSY;
            BUSY:    if (last_acc) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: the merged stream is a pure mux of the granted port,
    // gated so nothing leaks out while idle.
    always_comb begin
        busy          = (state == BUSY);
        m_axis.tdata  = s_axis.tdata[int'(gsel)*DW +: DW];
        m_axis.tstrb  = s_axis.tstrb[int'(gsel)*SW +: SW];
        m_axis.tuser  = s_axis.tuser[int'(gsel)*TUSER_W +: TUSER_W];
        m_axis.tuser[SRC_PORT_MSB:SRC_PORT_LSB] = src_port_code(grant_port);
        m_axis.tvalid = busy & s_axis.tvalid[gsel];
        m_axis.tlast  = busy & s_axis.tlast[gsel];
        s_axis.tready = '0;
        if (busy) s_axis.tready[gsel] = m_axis.tready[0];
    end

`ifdef AXIS_PKT_ARB_CNT_EN
    for (genvar i = 0; i < N; i++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;
        // NOTE: counters are software-visible state, so they are reset
        // explicitly rather than left to power-up values.
        always_ff @(posedge m_axis_aclk or posedge m_axis_aresetp) begin
            if (m_axis_aresetp)                   cnt_q <= '0;
            else if (last_acc && gsel == IW'(i))  cnt_q <= cnt_q + 1'b1;
        end
        assign pkt_cnt[i*CNT_W +: CNT_W] = cnt_q;
    end
`else
    assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_axis_pkt_arb.sv
// -----------------------------------------------------------------------------
// tb_axis_pkt_arb
// Self-checking bench for axis_pkt_arb (N=4, DW=64). Each port is fed from a
// queue of beats; a transaction-level model decides grants from the
// round-robin rule and retires beats on accepted handshakes. Directed
// scenarios are followed by a randomized traffic phase.
// -----------------------------------------------------------------------------
module tb_axis_pkt_arb;
    localparam int N  = 4;
    localparam int DW = 64;
    localparam int SW = DW / 8;

    typedef struct {
        logic [DW-1:0]  data;
        logic [SW-1:0]  strb;
        logic [127:0]   user;
        logic           last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axis_pkt_arb_if #(.NP(N), .DW(DW)) s_axis ();
    axis_pkt_arb_if #(.NP(1), .DW(DW)) m_axis ();
    logic [2:0]      grant_port;
    logic            busy;
    logic [N*32-1:0] pkt_cnt;

    axis_pkt_arb #(.N(N), .DW(DW)) dut (
        .m_axis_aclk    (clk),
        .m_axis_aresetp (rst),
        .s_axis         (s_axis),
        .m_axis         (m_axis),
        .grant_port     (grant_port),
        .busy           (busy),
        .pkt_cnt        (pkt_cnt)
    );

    // Sources and model state.
    beat_t       src_q [N][$];
    bit          stall [N];
    bit          m_rdy;
    bit          m_busy;
    int          m_grant;
    int          m_last;
    logic [31:0] m_cnt [N];

    // Observations of the DUT.
    int          dut_grants [$];
    bit          prev_busy;
    int          busy_cycles;
    int          hs_cnt;
    logic [7:0]  last_src;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic beat_t rand_beat(input bit last);
        beat_t b;
        b.data = {$urandom, $urandom};
        b.strb = SW'($urandom);
        b.user = {$urandom, $urandom, $urandom, $urandom};
        b.last = last;
        return b;
    endfunction

    task automatic enqueue(input int port, input int len);
        for (int b = 0; b < len; b++) src_q[port].push_back(rand_beat(b == len - 1));
    endtask

    function automatic bit any_pending();
        for (int i = 0; i < N; i++) if (src_q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_cnt(input int i);
`ifdef AXIS_PKT_ARB_CNT_EN
        return m_cnt[i];
`else
        return 32'd0;
`endif
    endfunction

    // One clock: drive at negedge, check 1 ns later, advance the model with
    // what the posedge will see.
    task automatic step();
        logic [N-1:0] vld;
        logic [N-1:0] exp_rdy;
        logic [127:0] exp_user;
        beat_t        hb;
        int           g;
        bit           granted;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            vld[i] = (src_q[i].size() > 0) && !stall[i];
            hb = (src_q[i].size() > 0) ? src_q[i][0] : rand_beat(1'b0);
            s_axis.tdata[i*DW +: DW]   = hb.data;
            s_axis.tstrb[i*SW +: SW]   = hb.strb;
            s_axis.tuser[i*128 +: 128] = hb.user;
            s_axis.tlast[i]            = hb.last;
        end
        s_axis.tvalid = vld;
        m_axis.tready = m_rdy;
        #1;
        if (busy === 1'b1) begin
            busy_cycles++;
            last_src = m_axis.tuser[23:16];
            if (!prev_busy) dut_grants.push_back(int'(grant_port));
        end
        if (m_axis.tvalid === 1'b1 && m_rdy) hs_cnt++;
        prev_busy = (busy === 1'b1);

        g = m_grant;
        check("busy", busy, m_busy);
        if (m_busy) begin
            exp_rdy    = '0;
            exp_rdy[g] = m_rdy;
            check("grant_port", grant_port, g);
            check("s_tready_busy", s_axis.tready, exp_rdy);
            check("m_tvalid_busy", m_axis.tvalid, vld[g]);
            if (vld[g]) begin
                hb = src_q[g][0];
                exp_user = hb.user;
                exp_user[23:16] = 8'((32'd1 << (2 * g)) & 32'hFF);
                check("m_tdata", m_axis.tdata, hb.data);
                check("m_tstrb", m_axis.tstrb, hb.strb);
                check("m_tuser", m_axis.tuser, exp_user);
                check("m_tlast", m_axis.tlast, hb.last);
            end
        end else begin
            check("m_tvalid_idle", m_axis.tvalid, 1'b0);
            check("s_tready_idle", s_axis.tready, '0);
        end
        for (int i = 0; i < N; i++) check("pkt_cnt", pkt_cnt[i*32 +: 32], exp_cnt(i));

        if (!m_busy) begin
            granted = 1'b0;
            for (int k = 1; k <= N; k++) begin
                if (!granted && vld[(m_last + k) % N]) begin
                    granted = 1'b1;
                    m_busy  = 1'b1;
                    m_grant = (m_last + k) % N;
                end
            end
        end else if (vld[g] && m_rdy) begin
            hb = src_q[g].pop_front();
            if (hb.last) begin
                m_busy   = 1'b0;
                m_last   = g;
                m_cnt[g] = m_cnt[g] + 32'd1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        check("pre_reset_busy", busy, m_busy);
        rst = 1'b1;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_m_tvalid", m_axis.tvalid, 1'b0);
        check("rst_s_tready", s_axis.tready, '0);
        check("rst_grant", grant_port, 3'd0);
        check("rst_pkt_cnt", pkt_cnt, '0);
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            m_cnt[i] = '0;
        end
        m_busy = 1'b0;
        m_last = N - 1;
        s_axis.tvalid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        prev_busy = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((any_pending() || m_busy) && n < budget) begin
            step();
            n++;
        end
        check("drain_done", any_pending() || m_busy, 1'b0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < N; i++) begin
            stall[i] = 1'b0;
            m_cnt[i] = '0;
        end
        m_rdy = 1'b1; m_busy = 1'b0; m_grant = 0; m_last = N - 1;
        s_axis.tdata = '0; s_axis.tstrb = '0; s_axis.tuser = '0;
        s_axis.tvalid = '0; s_axis.tlast = '0; m_axis.tready = '0;
        do_reset();

        // Single 3-beat packet on port 0.
        busy_cycles = 0; dut_grants.delete();
        enqueue(0, 3);
        drain(20);
        check("p0_busy_cycles", busy_cycles, 3);
        check("p0_grant", dut_grants.size() > 0 ? dut_grants[0] : -1, 0);
        check("p0_src_port", last_src, 8'h01);
`ifdef AXIS_PKT_ARB_CNT_EN
        check("p0_pkt_cnt", pkt_cnt[31:0], 32'd1);
`else
        check("p0_pkt_cnt", pkt_cnt[31:0], 32'd0);
`endif

        // All ports requesting 1-beat packets: rotation from port 0.
        do_reset();
        dut_grants.delete();
        enqueue(0, 1); enqueue(0, 1);
        for (int p = 1; p < N; p++) enqueue(p, 1);
        n = 0;
        while (dut_grants.size() < 5 && n < 40) begin step(); n++; end
        check("rr_grant_count", dut_grants.size(), 5);
        for (int j = 0; j < 5; j++)
            check("rr_order", j < dut_grants.size() ? dut_grants[j] : -1, j % N);
        for (int p = 0; p < N; p++)
`ifdef AXIS_PKT_ARB_CNT_EN
            check("rr_pkt_cnt", pkt_cnt[p*32 +: 32], 32'd1);
`else
            check("rr_pkt_cnt", pkt_cnt[p*32 +: 32], 32'd0);
`endif
        drain(20);

        // Port 2 with downstream ready toggling every cycle.
        hs_cnt = 0;
        enqueue(2, 6);
        m_rdy = 1'b1;
        for (int c = 0; c < 16; c++) begin
            step();
            m_rdy = ~m_rdy;
        end
        m_rdy = 1'b1;
        drain(20);
        check("p2_handshakes", hs_cnt, 6);

        // Port 1 stalls mid-packet while port 3 waits.
        dut_grants.delete();
        enqueue(1, 4);
        step(); step();
        enqueue(3, 2);
        stall[1] = 1'b1;
        repeat (5) step();
        stall[1] = 1'b0;
        drain(30);
        check("stall_grants", dut_grants.size(), 2);
        check("stall_first", dut_grants.size() > 0 ? dut_grants[0] : -1, 1);
        check("stall_second", dut_grants.size() > 1 ? dut_grants[1] : -1, 3);

        // Randomized traffic with random stalls and backpressure.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) stall[i] = ($urandom_range(0, 3) == 0);
            m_rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                n = $urandom_range(0, N - 1);
                if (src_q[n].size() < 10) enqueue(n, $urandom_range(1, 5));
            end
            step();
        end
        for (int i = 0; i < N; i++) stall[i] = 1'b0;
        m_rdy = 1'b1;
        drain(600);

        // Reset during beat 2 of a 4-beat packet on port 3.
        enqueue(3, 4);
        step(); step();
        do_reset();
        dut_grants.delete();
        enqueue(0, 1); enqueue(3, 1);
        drain(20);
        check("post_rst_first", dut_grants.size() > 0 ? dut_grants[0] : -1, 0);
        check("post_rst_second", dut_grants.size() > 1 ? dut_grants[1] : -1, 3);

`ifdef AXIS_PKT_ARB_CNT_EN
        // Counter wrap from all-ones.
        @(negedge clk);
        force dut.g_cnt[0].cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.g_cnt[0].cnt_q;
        m_cnt[0] = 32'hFFFF_FFFF;
        enqueue(0, 2);
        drain(20);
        check("cnt_wrap", pkt_cnt[31:0], 32'd0);
`else
        enqueue(0, 2);
        drain(20);
        check("cnt_disabled", pkt_cnt, '0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
